// File: rtl/rbm_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rbm_layer_sequencer
// Description : Control FSM that time-multiplexes one shared RBM
//               multiply-accumulate datapath across two layers:
//                 H pass : INPUT_DIM inputs  -> HIDDEN_DIM hidden units
//                 C pass : HIDDEN_DIM hidden -> OUTPUT_DIM class scores
//               Emits weight addresses, operand/unit indices and the
//               accumulator/activation strobes, and tracks the argmax of
//               the class scores.
// Ports       :
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       begin one inference (sampled only in IDLE)
//   stall       datapath back-pressure; freezes everything while high
//   score_in    signed class score, valid in C_ACT cycles
//   busy        high in every state except IDLE
//   layer_sel   0 = H pass, 1 = C pass
//   in_idx      operand index (input i or hidden j)
//   unit_idx    neuron currently being computed
//   w_addr      weight memory address
//   acc_clr     clear accumulator before adding this cycle's product
//   acc_en      accumulate this cycle's product
//   act_en      apply bias/activation for unit_idx
//   done        one-cycle completion pulse
//   result      argmax class, held until the next done
// Revision    : 1.0 - initial release
// ============================================================================
module rbm_layer_sequencer #(
  parameter int INPUT_DIM  = 15,
  parameter int HIDDEN_DIM = 5,
  parameter int OUTPUT_DIM = 2,
  parameter int BITLENGTH  = 12,
  parameter int IDX_W      = 4,
  parameter int ADDR_W     = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stall,
  input  logic signed [BITLENGTH-1:0] score_in,
  output logic                        busy,
  output logic                        layer_sel,
  output logic        [IDX_W-1:0]     in_idx,
  output logic        [IDX_W-1:0]     unit_idx,
  output logic        [ADDR_W-1:0]    w_addr,
  output logic                        acc_clr,
  output logic                        acc_en,
  output logic                        act_en,
  output logic                        done,
  output logic        [IDX_W-1:0]     result
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_H_ACC = 3'd1,
    ST_H_ACT = 3'd2,
    ST_C_ACC = 3'd3,
    ST_C_ACT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0]  IN_LAST  = IDX_W'(INPUT_DIM - 1);
  localparam logic [IDX_W-1:0]  HID_LAST = IDX_W'(HIDDEN_DIM - 1);
  localparam logic [IDX_W-1:0]  OUT_LAST = IDX_W'(OUTPUT_DIM - 1);
  localparam logic [ADDR_W-1:0] IN_STRIDE  = ADDR_W'(INPUT_DIM);
  localparam logic [ADDR_W-1:0] HID_STRIDE = ADDR_W'(HIDDEN_DIM);
  // C-layer weights are stored directly after the H-layer block.
  localparam logic [ADDR_W-1:0] C_BASE     = ADDR_W'(INPUT_DIM * HIDDEN_DIM);

  state_t                      state, state_nxt;
  logic        [IDX_W-1:0]     in_idx_q, in_idx_nxt;
  logic        [IDX_W-1:0]     unit_idx_q, unit_idx_nxt;
  logic signed [BITLENGTH-1:0] best_score, best_score_nxt;
  logic        [IDX_W-1:0]     best_idx, best_idx_nxt;
  logic        [IDX_W-1:0]     result_q, result_nxt;
  logic        [ADDR_W-1:0]    h_addr, c_addr;

  assign h_addr = ADDR_W'(unit_idx_q) * IN_STRIDE + ADDR_W'(in_idx_q);
  assign c_addr = C_BASE + ADDR_W'(unit_idx_q) * HID_STRIDE + ADDR_W'(in_idx_q);

  assign in_idx   = in_idx_q;
  assign unit_idx = unit_idx_q;

  // All state advances only on non-stalled cycles, so every strobe (being a
  // function of this state) holds its value for the whole stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_idx_q   <= '0;
      unit_idx_q <= '0;
      best_score <= '0;
      best_idx   <= '0;
      result_q   <= '0;
    end else if (!stall) begin
      state      <= state_nxt;
      in_idx_q   <= in_idx_nxt;
      unit_idx_q <= unit_idx_nxt;
      best_score <= best_score_nxt;
      best_idx   <= best_idx_nxt;
      result_q   <= result_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    in_idx_nxt     = in_idx_q;
    unit_idx_nxt   = unit_idx_q;
    best_score_nxt = best_score;
    best_idx_nxt   = best_idx;
    result_nxt     = result_q;
    busy           = 1'b1;
    layer_sel      = 1'b0;
    acc_clr        = 1'b0;
    acc_en         = 1'b0;
    act_en         = 1'b0;
    done           = 1'b0;
    w_addr         = '0;
    result         = result_q;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt    = ST_H_ACC;
          in_idx_nxt   = '0;
          unit_idx_nxt = '0;
        end
      end

      ST_H_ACC: begin
        acc_en  = 1'b1;
        acc_clr = (in_idx_q == '0);
        w_addr  = h_addr;
        // Index saturates at its limit; it is cleared on leaving the ACT state.
        if (in_idx_q == IN_LAST) state_nxt = ST_H_ACT;
        else                     in_idx_nxt = in_idx_q + 1'b1;
      end

      ST_H_ACT: begin
        act_en     = 1'b1;
        w_addr     = h_addr;
        in_idx_nxt = '0;
        if (unit_idx_q == HID_LAST) begin
          unit_idx_nxt = '0;
          state_nxt    = ST_C_ACC;
        end else begin
          unit_idx_nxt = unit_idx_q + 1'b1;
          state_nxt    = ST_H_ACC;
        end
      end

      ST_C_ACC: begin
        layer_sel = 1'b1;
        acc_en    = 1'b1;
        acc_clr   = (in_idx_q == '0);
        w_addr    = c_addr;
        if (in_idx_q == HID_LAST) state_nxt = ST_C_ACT;
        else                      in_idx_nxt = in_idx_q + 1'b1;
      end

      ST_C_ACT: begin
        layer_sel  = 1'b1;
        act_en     = 1'b1;
        w_addr     = c_addr;
        in_idx_nxt = '0;
        // Strictly-greater replacement keeps the lowest index on ties.
        if (unit_idx_q == '0 || score_in > best_score) begin
          best_score_nxt = score_in;
          best_idx_nxt   = unit_idx_q;
        end
        if (unit_idx_q == OUT_LAST) begin
          unit_idx_nxt = '0;
          state_nxt    = ST_DONE;
        end else begin
          unit_idx_nxt = unit_idx_q + 1'b1;
          state_nxt    = ST_C_ACC;
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        // Publish the winner in the same cycle as the done pulse.
        result     = best_idx;
        result_nxt = best_idx;
        state_nxt  = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/rbm_layer_sequencer.md
Name: rbm_layer_sequencer

Overview:
- Control FSM that time-multiplexes one shared RBM multiply-accumulate datapath across the two layers of the network.
- Pass H: input_dim inputs into hidden_dim hidden units (sigmoid plus stochastic sample). Pass C: hidden_dim hidden units into output_dim class scores.
- Generates weight-memory addresses, operand indices, accumulator and activation strobes, and tracks the argmax of the class scores.
- Sits between the top-level network wrapper (start/done) and the RBM layer datapath.

Parameters:
- INPUT_DIM, 15, visible inputs per sample
- HIDDEN_DIM, 5, hidden units
- OUTPUT_DIM, 2, classes
- BITLENGTH, 12, signed width of the class score from the datapath
- IDX_W, 4, width of operand/unit indices; must satisfy 2^IDX_W >= max(INPUT_DIM, HIDDEN_DIM, OUTPUT_DIM)
- ADDR_W, 7, weight address width; must satisfy 2^ADDR_W >= INPUT_DIM*HIDDEN_DIM + HIDDEN_DIM*OUTPUT_DIM

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one inference; sampled only in IDLE
- stall  in  1  datapath back-pressure; when high, all state, counters and outputs hold
- score_in  in  BITLENGTH  signed class score from the datapath, valid in C_ACT cycles
- busy  out  1  high in every state except IDLE
- layer_sel  out  1  0 = H pass, 1 = C pass
- in_idx  out  IDX_W  current operand index (input i or hidden j)
- unit_idx  out  IDX_W  current neuron being computed
- w_addr  out  ADDR_W  weight address
- acc_clr  out  1  clear the accumulator before adding this cycle's product
- acc_en  out  1  accumulate this cycle's product
- act_en  out  1  apply bias/activation for unit_idx (H: sigmoid+sample into hidden buffer; C: present score)
- done  out  1  one-cycle completion pulse
- result  out  IDX_W  argmax class, held until the next done

Behaviour:
- Reset: state=IDLE. All outputs 0, including result and all counters. Reset is asynchronous and takes effect mid-operation; no partial result is published.
- States: IDLE, H_ACC, H_ACT, C_ACC, C_ACT, DONE.
- IDLE -> H_ACC when start=1 (and stall=0). in_idx=0, unit_idx=0.
- H_ACC:
  - acc_en=1 every cycle.
  - acc_clr=1 only when in_idx=0.
  - w_addr = unit_idx*INPUT_DIM + in_idx.
  - in_idx increments each cycle. When in_idx=INPUT_DIM-1 -> H_ACT.
- H_ACT: one cycle, act_en=1, acc_en=0. Then:
  - if unit_idx=HIDDEN_DIM-1 -> C_ACC with unit_idx=0, in_idx=0;
  - else unit_idx+1, in_idx=0 -> H_ACC.
- C_ACC: same as H_ACC with layer_sel=1, limit HIDDEN_DIM-1, and w_addr = INPUT_DIM*HIDDEN_DIM + unit_idx*HIDDEN_DIM + in_idx.
- C_ACT: one cycle, act_en=1. Sample score_in (signed compare):
  - unit_idx=0: best_score<=score_in, best_idx<=0.
  - otherwise replace only if score_in > best_score (strict). Ties keep the lower index.
  - Then next unit, or DONE after unit OUTPUT_DIM-1.
- DONE: one cycle. done=1, result<=best_idx (visible the same cycle). Next state IDLE.
- Latency: with stall=0 and start accepted at edge E, the FSM spends HIDDEN_DIM*(INPUT_DIM+1) + OUTPUT_DIM*(HIDDEN_DIM+1) cycles in the compute states, then DONE. Default = 80 + 12 = 92, so done is high in the 93rd cycle after E.
- stall=1: freezes state, counters, best registers and all strobe outputs. Strobes stay asserted at their held value; the datapath must ignore them while it stalls itself. The C_ACT sample is taken only on the non-stalled cycle.
- start while busy: ignored. start held high through DONE: a new run begins on the cycle after returning to IDLE.
- in_idx, unit_idx and w_addr are 0 outside the ACC/ACT states. Counters never exceed their limits (no wrap).

Test Plan:
- Reset then idle: rst_n low, pulse start -> busy=0, all outputs 0. Release reset, start=1 one cycle -> busy=1 next cycle, w_addr=0, acc_clr=1.
- Full run with defaults, stall=0:
  - w_addr steps 0..14, act_en, 15..29, ...; first C_ACC address is 75; last C address is 84.
  - done pulses exactly once, 93 cycles after start is accepted.
  - Counts: 5 H act_en pulses, 2 C act_en pulses, acc_clr count 7.
- Argmax:
  - scores {-3, 7} -> result=1.
  - scores {5, 5} -> result=0 (tie).
  - scores {-100, -200} -> result=0.
  - result holds after done until the next run.
- Stall: assert stall for 4 cycles at H cycle 20 and 3 cycles inside C_ACT -> outputs frozen during stall; done arrives at cycle 93+7; argmax is unchanged versus the unstalled run.
- Reset mid-run: drop rst_n during C_ACC -> immediate IDLE with outputs 0. Next start completes normally; result reflects only the new run.
- Start during busy: pulse start at cycle 40 -> no effect; single done at cycle 93.
